multicycle_ctrl: RTL and testbench

//  Parametrised multicycle control FSM for the TinyV core.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// TinyV multicycle control FSM: fetch/decode/execute/mem/writeback with memory timeout and traps.
// Latency (zero memory wait): JMP/JMPI/BR 3, ALU/ALUI/ST 4, LD 5 cycles; outputs decoded from state and inputs.
// Backpressure: mem_req held until mem_ready or timeout trap; optional irq trap via TINYV_CTRL_IRQ_EN.
module multicycle_ctrl #(
    parameter int OPCODE_W     = 4,
    parameter int ALU_SEL_W    = 3,
    parameter int ALU_ADD_CODE = 0,
    parameter int ALU_CMP_CODE = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [ALU_SEL_W-1:0] funct,
    input  logic                 br_taken,
    input  logic                 mem_ready,
`ifdef TINYV_CTRL_IRQ_EN
    input  logic                 irq,
    output logic                 irq_ack,
`endif
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_adr_sel,
    output logic                 ir_load,
    output logic                 pc_ctrl,
    output logic [1:0]           pc_wr_sel,
    output logic [ALU_SEL_W-1:0] alu_op,
    output logic                 alu_a_sel,
    output logic [1:0]           alu_b_sel,
    output logic                 reg_we,
    output logic                 reg_data_sel,
    output logic [1:0]           reg_w_sel,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic                 halted
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [ALU_SEL_W-1:0] OP_ADD = ALU_SEL_W'(ALU_ADD_CODE);
    localparam logic [ALU_SEL_W-1:0] OP_CMP = ALU_SEL_W'(ALU_CMP_CODE);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_JMP, S_JMPI, S_ALU_EX, S_ALUI_EX, S_ALU_RR, S_ALUI_RR,
        S_BR, S_LD_ST, S_LD_MEM, S_LD_RR, S_ST_MEM, S_TRAP, S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             req_state;
    logic             timed_out;
    logic             to_fetch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cause_d   = cause_q;
        to_fetch  = 1'b0;
        req_state = (state_q == S_FETCH) || (state_q == S_LD_MEM) || (state_q == S_ST_MEM);
        timed_out = (MEM_TIMEOUT > 0) && req_state && !mem_ready && (cnt_q == CNT_LAST);
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if ((opcode >> 3) != '0) begin
                    state_d = S_TRAP;
                    cause_d = 2'd0;
                end else begin
                    case (opcode[2:0])
                        3'd0:    state_d = S_JMP;
                        3'd1:    state_d = S_JMPI;
                        3'd2:    state_d = S_ALU_EX;
                        3'd3:    state_d = S_ALUI_EX;
                        3'd4:    state_d = S_BR;
                        3'd5,
                        3'd6:    state_d = S_LD_ST;
                        default: state_d = S_HALTED;
                    endcase
                end
            end
            S_ALU_EX:  state_d = S_ALU_RR;
            S_ALUI_EX: state_d = S_ALUI_RR;
            S_LD_ST:   state_d = (opcode[2:0] == 3'd5) ? S_LD_MEM : S_ST_MEM;
            S_LD_MEM:  if (mem_ready) state_d = S_LD_RR;
            S_ST_MEM:  if (mem_ready) to_fetch = 1'b1;
            S_JMP, S_JMPI, S_ALU_RR, S_ALUI_RR, S_BR, S_LD_RR: to_fetch = 1'b1;
            S_TRAP:    state_d = S_FETCH;
            S_HALTED:  state_d = S_HALTED;
            default:   state_d = S_FETCH;
        endcase

        // Instruction completion is the only point where a pending interrupt is taken.
        if (to_fetch) begin
            state_d = S_FETCH;
`ifdef TINYV_CTRL_IRQ_EN
            if (irq) begin
                state_d = S_TRAP;
                cause_d = 2'd3;
            end
`endif
        end

        if (req_state && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
        if (timed_out) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_adr_sel  = 1'b0;
        ir_load      = 1'b0;
        pc_ctrl      = 1'b0;
        pc_wr_sel    = 2'b00;
        alu_op       = '0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 2'b00;
        reg_we       = 1'b0;
        reg_data_sel = 1'b0;
        reg_w_sel    = 2'b00;
        trap         = 1'b0;
        trap_cause   = 2'b00;
        halted       = 1'b0;
`ifdef TINYV_CTRL_IRQ_EN
        irq_ack      = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alu_op  = OP_ADD;
                    ir_load = mem_ready;
                    pc_ctrl = mem_ready;
                end
                S_DECODE: begin
                    alu_op    = OP_ADD;
                    alu_b_sel = 2'b10;
                end
                S_JMP: begin
                    pc_wr_sel = 2'b10;
                    pc_ctrl   = 1'b1;
                end
                S_JMPI:    pc_ctrl = 1'b1;
                S_ALU_EX, S_ALUI_EX: begin
                    alu_op    = funct;
                    alu_a_sel = 1'b1;
                    alu_b_sel = (state_q == S_ALUI_EX) ? 2'b10 : 2'b00;
                end
                S_ALU_RR, S_ALUI_RR: begin
                    reg_we       = 1'b1;
                    reg_data_sel = 1'b1;
                    reg_w_sel    = (state_q == S_ALUI_RR) ? 2'b01 : 2'b00;
                end
                S_BR: begin
                    alu_op    = OP_CMP;
                    alu_a_sel = 1'b1;
                    pc_wr_sel = 2'b01;
                    pc_ctrl   = br_taken;
                end
                S_LD_ST: begin
                    alu_op    = OP_ADD;
                    alu_a_sel = 1'b1;
                    alu_b_sel = 2'b10;
                end
                S_LD_MEM: begin
                    mem_req     = 1'b1;
                    mem_adr_sel = 1'b1;
                end
                S_LD_RR: begin
                    reg_we    = 1'b1;
                    reg_w_sel = 2'b01;
                end
                S_ST_MEM: begin
                    mem_req     = 1'b1;
                    mem_we      = 1'b1;
                    mem_adr_sel = 1'b1;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                    pc_wr_sel  = 2'b11;
                    pc_ctrl    = 1'b1;
`ifdef TINYV_CTRL_IRQ_EN
                    irq_ack    = (cause_q == 2'd3);
`endif
                end
                S_HALTED:  halted = 1'b1;
                default:   halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl: a procedural per-instruction model
// predicts every cycle's outputs; a single compare process checks them each cycle.
module tb_multicycle_ctrl;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [2:0] funct = 3'd0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_adr_sel, ir_load, pc_ctrl;
    logic [1:0] pc_wr_sel, alu_b_sel, reg_w_sel, trap_cause;
    logic [2:0] alu_op;
    logic       alu_a_sel, reg_we, reg_data_sel, trap, halted;
`ifdef TINYV_CTRL_IRQ_EN
    logic       irq = 1'b0;
    logic       irq_ack;
`endif

    multicycle_ctrl #(.OPCODE_W(4), .ALU_SEL_W(3), .ALU_ADD_CODE(0), .ALU_CMP_CODE(1),
                      .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .br_taken(br_taken),
        .mem_ready(mem_ready),
`ifdef TINYV_CTRL_IRQ_EN
        .irq(irq), .irq_ack(irq_ack),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr_sel(mem_adr_sel), .ir_load(ir_load),
        .pc_ctrl(pc_ctrl), .pc_wr_sel(pc_wr_sel), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .reg_we(reg_we), .reg_data_sel(reg_data_sel),
        .reg_w_sel(reg_w_sel), .trap(trap), .trap_cause(trap_cause), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, mem_adr_sel, ir_load, pc_ctrl;
        logic [1:0] pc_wr_sel;
        logic [2:0] alu_op;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       reg_we, reg_data_sel;
        logic [1:0] reg_w_sel;
        logic       trap;
        logic [1:0] trap_cause;
        logic       halted, irq_ack;
    } exp_t;

    int    checks = 0;
    int    failures = 0;
    bit    chk_en = 1'b0;
    exp_t  exp_cur;
    string exp_name = "";
    int    last_mem_n = 0;
    bit    irq_in_ex = 1'b0;

    function automatic exp_t actual();
        exp_t a;
        a = '0;
        a.mem_req = mem_req;     a.mem_we = mem_we;         a.mem_adr_sel = mem_adr_sel;
        a.ir_load = ir_load;     a.pc_ctrl = pc_ctrl;       a.pc_wr_sel = pc_wr_sel;
        a.alu_op = alu_op;       a.alu_a_sel = alu_a_sel;   a.alu_b_sel = alu_b_sel;
        a.reg_we = reg_we;       a.reg_data_sel = reg_data_sel; a.reg_w_sel = reg_w_sel;
        a.trap = trap;           a.trap_cause = trap_cause; a.halted = halted;
`ifdef TINYV_CTRL_IRQ_EN
        a.irq_ack = irq_ack;
`endif
        return a;
    endfunction

    // Single compare point: outputs settle combinationally, sampled 2ns after the input-update edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            checks++;
            if (actual() !== exp_cur) begin
                failures++;
                $display("FAIL %s t=%0t actual=%h expected=%h", exp_name, $time, actual(), exp_cur);
            end
        end
    end

    task automatic pin(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, want);
        end
    endtask

    task automatic cyc(input string name, input exp_t e);
        exp_cur  = e;
        exp_name = name;
        chk_en   = 1'b1;
        @(negedge clk);
    endtask

    task automatic noise();
        mem_ready = 1'($urandom_range(0, 1));
        br_taken  = 1'($urandom_range(0, 1));
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return int'($urandom_range(0, 3));
        if (r < 13) return int'($urandom_range(4, 14));
        if (r == 13) return TO - 1;
        return -1;
    endfunction

    task automatic do_reset();
        exp_t z;
        z = '0;
        reset = 1'b1;
        noise();
        cyc("in_reset", z);
        noise();
        cyc("in_reset", z);
        reset = 1'b0;
    endtask

    task automatic trap_cyc(input logic [1:0] cause);
        exp_t e;
        e = '0;
        e.trap = 1'b1; e.trap_cause = cause; e.pc_wr_sel = 2'b11; e.pc_ctrl = 1'b1;
        e.irq_ack = (cause == 2'd3);
        noise();
        cyc("trap", e);
    endtask

    // A request waits delay not-ready cycles then sees ready; delay<0 never sees ready.
    task automatic mem_phase(input string name, input exp_t base, input bit is_fetch,
                             input int delay, output bit ok);
        exp_t e;
        ok = 1'b0;
        last_mem_n = 0;
        for (int n = 0; n < TO; n++) begin
            mem_ready = (delay >= 0) && (n == delay);
            br_taken  = 1'($urandom_range(0, 1));
            if (is_fetch) begin
                opcode = 4'($urandom);
                funct  = 3'($urandom);
            end
            e = base;
            if (is_fetch && mem_ready) begin
                e.ir_load = 1'b1;
                e.pc_ctrl = 1'b1;
            end
            cyc(name, e);
            last_mem_n++;
            if (mem_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic to_fetch();
`ifdef TINYV_CTRL_IRQ_EN
        if (irq) trap_cyc(2'd3);
`endif
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input int fd,
                             input int md, input bit br, output int ncyc);
        exp_t e;
        bit   ok;
        e = '0;
        e.mem_req = 1'b1;
        mem_phase("fetch", e, 1'b1, fd, ok);
        ncyc = last_mem_n;
        if (!ok) begin
            trap_cyc(2'd1);
            return;
        end
        opcode = op;
        funct  = fn;
        noise();
        e = '0; e.alu_b_sel = 2'b10;
        cyc("decode", e);
        ncyc++;
        if (op > 4'd7) begin
            trap_cyc(2'd0);
            return;
        end
        e = '0;
        noise();
        case (op)
            4'd0: begin
                e.pc_wr_sel = 2'b10; e.pc_ctrl = 1'b1;
                cyc("jmp", e); ncyc++;
            end
            4'd1: begin
                e.pc_ctrl = 1'b1;
                cyc("jmpi", e); ncyc++;
            end
            4'd2, 4'd3: begin
`ifdef TINYV_CTRL_IRQ_EN
                if (irq_in_ex) irq = 1'b1;
`endif
                e.alu_op = fn; e.alu_a_sel = 1'b1;
                e.alu_b_sel = (op == 4'd3) ? 2'b10 : 2'b00;
                cyc("alu_ex", e); ncyc++;
                e = '0;
                noise();
                e.reg_we = 1'b1; e.reg_data_sel = 1'b1;
                e.reg_w_sel = (op == 4'd3) ? 2'b01 : 2'b00;
                cyc("alu_rr", e); ncyc++;
            end
            4'd4: begin
                br_taken = br;
                e.alu_op = 3'd1; e.alu_a_sel = 1'b1; e.pc_wr_sel = 2'b01; e.pc_ctrl = br;
                cyc("br", e); ncyc++;
            end
            4'd5, 4'd6: begin
                e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b10;
                cyc("ld_st", e); ncyc++;
                e = '0;
                e.mem_req = 1'b1; e.mem_adr_sel = 1'b1; e.mem_we = (op == 4'd6);
                mem_phase((op == 4'd5) ? "ld_mem" : "st_mem", e, 1'b0, md, ok);
                ncyc += last_mem_n;
                if (!ok) begin
                    trap_cyc(2'd1);
                    return;
                end
                if (op == 4'd5) begin
                    e = '0;
                    noise();
                    e.reg_we = 1'b1; e.reg_w_sel = 2'b01;
                    cyc("ld_rr", e); ncyc++;
                end
            end
            default: begin
                e.halted = 1'b1;
                for (int i = 0; i < 100; i++) begin
                    noise();
                    opcode = 4'($urandom);
                    cyc("halted", e);
                    ncyc++;
                end
                do_reset();
                return;
            end
        endcase
        to_fetch();
    endtask

    initial begin
        int   n;
        exp_t e;
        @(negedge clk);
        do_reset();

        // Reset pulse in the middle of a fetch, then ADD retires in 4 cycles.
        e = '0; e.mem_req = 1'b1;
        mem_ready = 1'b0; cyc("fetch_pre", e);
        mem_ready = 1'b0; cyc("fetch_pre", e);
        do_reset();
        run_instr(4'd2, 3'd0, 0, 0, 1'b0, n);
        pin("add_latency", n, 4);
        run_instr(4'd3, 3'd5, 0, 0, 1'b0, n);
        pin("alui_latency", n, 4);

        run_instr(4'd5, 3'd2, 0, 3, 1'b0, n);
        pin("ld_mem_req_cycles", last_mem_n, 4);
        pin("ld_total_cycles", n, 8);
        run_instr(4'd6, 3'd1, 0, 0, 1'b0, n);
        pin("st_latency", n, 4);
        run_instr(4'd0, 3'd1, 0, 0, 1'b0, n);
        pin("jmp_latency", n, 3);

        run_instr(4'd2, 3'd3, -1, 0, 1'b0, n);
        pin("timeout_req_cycles", last_mem_n, 15);
        run_instr(4'd1, 3'd0, TO - 1, 0, 1'b0, n);
        pin("ready_at_limit_cycles", n, 17);

        run_instr(4'd4, 3'd0, 0, 0, 1'b0, n);
        run_instr(4'd4, 3'd0, 0, 0, 1'b1, n);
        pin("br_latency", n, 3);
        run_instr(4'd9, 3'd0, 0, 0, 1'b0, n);
        run_instr(4'd6, 3'd0, 0, -1, 1'b0, n);
        run_instr(4'd7, 3'd0, 0, 0, 1'b0, n);
        pin("halt_cycles", n, 102);

`ifdef TINYV_CTRL_IRQ_EN
        irq_in_ex = 1'b1;
        run_instr(4'd2, 3'd6, 0, 0, 1'b0, n);
        irq_in_ex = 1'b0;
        irq = 1'b0;
        run_instr(4'd1, 3'd0, 0, 0, 1'b0, n);
`endif

        for (int k = 0; k < 300; k++) begin
            int         r;
            logic [3:0] op;
            r = int'($urandom_range(0, 19));
            if (r < 14)      op = 4'(r % 7);
            else if (r < 18) op = 4'($urandom_range(8, 15));
            else             op = 4'd7;
`ifdef TINYV_CTRL_IRQ_EN
            irq = ($urandom_range(0, 7) == 0);
`endif
            run_instr(op, 3'($urandom), rand_delay(), rand_delay(),
                      1'($urandom_range(0, 1)), n);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
